// File: rtl/eth_tx_pkt_buf.sv
// eth_tx_pkt_buf: single-packet store-and-forward buffer feeding the RMII transmitter
module eth_tx_pkt_buf #(
  parameter int pMAX_LEN        = 256,
  parameter int pBYTE_CYCLES    = 4,
  parameter int pOVERHEAD_BYTES = 38,
  parameter int pMIN_PAYLOAD    = 46
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] In_Data,
  input  logic       In_Valid,
  input  logic       In_Last,
  output logic       In_Ready,
  output logic [9:0] Eth_Byte,
  output logic       Eth_Byte_Valid,
  output logic       Busy,
  output logic       Drop
);
  localparam int CW = $clog2(pMAX_LEN + 1);
  localparam int AW = (pMAX_LEN > 1) ? $clog2(pMAX_LEN) : 1;
  localparam int GW = $clog2((pMAX_LEN + pOVERHEAD_BYTES) * pBYTE_CYCLES + 1);
  typedef enum logic [1:0] {FILL, DISCARD, BURST, HOLDOFF} state_t;
  state_t state;
  logic [7:0] mem [pMAX_LEN];
  logic [CW-1:0] count, len, lenM1;
  logic [GW-1:0] gap, gapTarget;
  logic accept, full;
  int padLen;
  assign In_Ready = !Rst && (state == FILL || state == DISCARD);
  assign Busy = state == BURST || state == HOLDOFF;
  assign accept = In_Valid && In_Ready;
  assign full = count == CW'(pMAX_LEN);
  assign lenM1 = len - CW'(1);
  // Short payloads are padded on the wire, so the hold-off covers at least the minimum frame
  assign padLen = (int'(len) < pMIN_PAYLOAD) ? pMIN_PAYLOAD : int'(len);
  assign gapTarget = GW'((padLen + pOVERHEAD_BYTES) * pBYTE_CYCLES);
  // Buffer write port; contents survive reset and are simply overwritten by the next packet
  always_ff @(posedge Clk)
    if (state == FILL && accept && !full) mem[count[AW-1:0]] <= In_Data;
  // Packet FSM: fill or discard, burst out with registered RAM read, then wait for the wire
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= FILL;
      count <= '0;
      len <= '0;
      gap <= '0;
      Eth_Byte <= '0;
      Eth_Byte_Valid <= 1'b0;
      Drop <= 1'b0;
    end else begin
      Drop <= 1'b0;
      Eth_Byte_Valid <= 1'b0;
      unique case (state)
        FILL: if (accept) begin
          if (!full) begin
            count <= In_Last ? '0 : count + CW'(1);
            if (In_Last) begin
              len <= count + CW'(1);
              state <= BURST;
            end
          end else if (In_Last) begin
            Drop <= 1'b1;
            count <= '0;
          end else state <= DISCARD;
        end
        DISCARD: if (accept && In_Last) begin
          Drop <= 1'b1;
          count <= '0;
          state <= FILL;
        end
        BURST: begin
          Eth_Byte <= {count == '0, count == lenM1, mem[count[AW-1:0]]};
          Eth_Byte_Valid <= 1'b1;
          count <= count + CW'(1);
          gap <= (gap == gapTarget) ? gap : gap + GW'(1);
          if (count == lenM1) state <= HOLDOFF;
        end
        HOLDOFF: if (gap == gapTarget) begin
          gap <= '0;
          count <= '0;
          state <= FILL;
        end else gap <= gap + GW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// tb_eth_tx_pkt_buf: directed packet vectors plus reset and held-valid corner sequences
module tb_eth_tx_pkt_buf;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [7:0] In_Data = '0;
  logic In_Valid = 1'b0;
  logic In_Last = 1'b0;
  logic In_Ready;
  logic [9:0] Eth_Byte;
  logic Eth_Byte_Valid;
  logic Busy;
  logic Drop;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int data;
  } out_t;
  typedef struct {
    int len;
    int base;
    int step;
    bit gaps;
    bit expDrop;
    int expG;
  } vec_t;

  out_t outQ[$];
  int dropQ[$];
  vec_t vecs[7];

  eth_tx_pkt_buf dut (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Last(In_Last),
    .In_Ready(In_Ready), .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid),
    .Busy(Busy), .Drop(Drop)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (Eth_Byte_Valid) outQ.push_back('{cyc, int'(Eth_Byte)});
    if (Drop) dropQ.push_back(cyc);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic sendPkt(input int len, input int base, input int step, input bit gaps,
                         output int tLast);
    int i = 0;
    int guard = 0;
    tLast = -1;
    while (i < len) begin
      @(negedge Clk);
      In_Valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      In_Data = 8'(base + i * step);
      In_Last = (i == len - 1);
      if (In_Valid && In_Ready) begin
        if (In_Last) tLast = cyc;
        i++;
      end
      guard++;
      if (guard > 20 * len + 100) begin
        chk("send_timeout", i, len);
        break;
      end
    end
    @(negedge Clk);
    In_Valid = 1'b0;
    In_Last = 1'b0;
  endtask

  task automatic runVec(input vec_t v);
    int t;
    int rc;
    int e;
    outQ.delete();
    dropQ.delete();
    sendPkt(v.len, v.base, v.step, v.gaps, t);
    if (v.expDrop) begin
      repeat (5) @(negedge Clk);
      chk("drop_no_out", outQ.size(), 0);
      chk("drop_count", dropQ.size(), 1);
      if (dropQ.size() > 0) chk("drop_cycle", dropQ[0], t + 1);
      chk("drop_ready", int'(In_Ready), 1);
    end else begin
      rc = -1;
      for (int k = 0; k < 2000; k++) begin
        @(negedge Clk);
        if (k == 0) chk("busy_holdoff", int'(Busy), 1);
        if (In_Ready) begin
          rc = cyc;
          break;
        end
      end
      chk("out_count", outQ.size(), v.len);
      for (int i = 0; i < outQ.size() && i < v.len; i++) begin
        e = {1'(i == 0), 1'(i == v.len - 1), 8'(v.base + i * v.step)};
        chk("out_byte", outQ[i].data, e);
        chk("out_cycle", outQ[i].cyc, t + 2 + i);
      end
      chk("gap", rc - t - 2, v.expG);
      chk("busy_end", int'(Busy), 0);
      chk("no_drop", dropQ.size(), 0);
    end
  endtask

  initial begin
    int t;
    int rc;
    int eops;
    vecs[0] = '{3, 8'hAA, 8'h11, 1'b0, 1'b0, 336};
    vecs[1] = '{60, 0, 1, 1'b1, 1'b0, 392};
    vecs[2] = '{256, 0, 1, 1'b0, 1'b0, 1176};
    vecs[3] = '{300, 5, 1, 1'b0, 1'b1, 0};
    vecs[4] = '{2, 8'h11, 8'h11, 1'b0, 1'b0, 336};
    vecs[5] = '{46, 3, 7, 1'b0, 1'b0, 336};
    vecs[6] = '{47, 9, 5, 1'b1, 1'b0, 340};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", int'(In_Ready), 0);
    chk("rst_byte", int'(Eth_Byte), 0);
    chk("rst_valid", int'(Eth_Byte_Valid), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_drop", int'(Drop), 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_release_ready", int'(In_Ready), 1);

    foreach (vecs[i]) runVec(vecs[i]);

    outQ.delete();
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data = 8'h5A;
    In_Last = 1'b1;
    chk("single_ready", int'(In_Ready), 1);
    t = cyc;
    @(negedge Clk);
    In_Data = 8'h77;
    rc = -1;
    for (int k = 0; k < 2000; k++) begin
      if (In_Ready) begin
        In_Valid = 1'b0;
        In_Last = 1'b0;
        rc = cyc;
        break;
      end
      @(negedge Clk);
    end
    In_Valid = 1'b0;
    In_Last = 1'b0;
    repeat (3) @(negedge Clk);
    chk("single_count", outQ.size(), 1);
    if (outQ.size() > 0) begin
      chk("single_byte", outQ[0].data, 10'h35A);
      chk("single_cycle", outQ[0].cyc, t + 2);
    end
    chk("single_gap", rc - t - 2, 336);
    chk("single_no_extra", int'(Busy), 0);

    outQ.delete();
    sendPkt(20, 8'h40, 3, 1'b0, t);
    repeat (5) @(posedge Clk);
    #1 Rst = 1'b1;
    @(negedge Clk);
    chk("midrst_ready_low", int'(In_Ready), 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("midrst_ready_high", int'(In_Ready), 1);
    chk("midrst_valid_low", int'(Eth_Byte_Valid), 0);
    repeat (30) @(negedge Clk);
    chk("midrst_out_count", outQ.size(), 5);
    eops = 0;
    foreach (outQ[i]) if (outQ[i].data[8]) eops++;
    chk("midrst_no_eop", eops, 0);
    if (outQ.size() > 0) chk("midrst_first", outQ[0].data, 10'h240);
    runVec('{5, 8'h90, 1, 1'b0, 1'b0, 336});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
